fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage of the sequential Y86-64 core. Owns the PC, reads instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake, assembles and length-decodes the instruction, and presents icode/ifun/rA/rB/valC/valP to decode with a valid/ready handshake. Tracks processor status (AOK/HLT/ADR/INS) and stops fetching on halt or error.

## Interface
- RESET_PC, 0, PC loaded on reset (64-bit).
- IMEM_SIZE, 1024, instruction memory size in bytes; addresses >= IMEM_SIZE are address errors.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins fetching from pc when IDLE
- new_pc  in  64  next PC from execute/write-back
- new_pc_valid  in  1  new_pc qualifier
- imem_req  out  1  byte read request
- imem_addr  out  64  byte address
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  8  read byte
- inst_valid  out  1  instruction fields valid
- inst_ready  in  1  decode accepts instruction
- icode, ifun, rA, rB  out  4 each  instruction fields
- valC  out  64  constant word, little-endian
- valP  out  64  pc + instruction length
- pc  out  64  current PC
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  high in FETCH, PRESENT, WAIT_PC

## Operation
- States: IDLE, FETCH, PRESENT, WAIT_PC, HALT.
- IDLE: start=1 -> FETCH, byte index k=0. start is ignored in every other state.
- FETCH: imem_req=1, imem_addr=pc+k. On imem_ack, capture imem_rdata into byte k and increment k.
  - Byte 0: icode=[7:4], ifun=[3:0]. Byte 1, if fetched: rA=[7:4], rB=[3:0].
  - valC: bytes 1..8 for 7/8 (jXX, call); bytes 2..9 for 3/4/5 (irmovq, rmmovq, mrmovq); otherwise 0.
  - Lengths: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10.
  - After the last byte -> PRESENT with valP=pc+length.
- Validity is checked on the byte-0 ack. icode>0xB, ifun!=0 (except ifun<=6 for 2 and 7, ifun<=3 for 6) -> stat=INS, HALT. No inst_valid.
- Address check happens before each request. If pc+k >= IMEM_SIZE, no request is issued: stat=ADR, HALT.
- PRESENT: inst_valid=1, fields held stable until inst_ready.
  - On acceptance of icode 0 (halt): stat=HLT -> HALT.
  - On any other acceptance -> WAIT_PC.
- WAIT_PC: on new_pc_valid, pc<=new_pc -> FETCH with k=0.
- Acceptance and new_pc_valid in the same cycle: load new_pc and go directly to FETCH.
- new_pc_valid is ignored in IDLE, FETCH and HALT.
- HALT: imem_req=0, inst_valid=0. Only rst exits HALT.
- Arithmetic is 64-bit modulo 2^64. pc+k wrap-around yields a small address and is not an error by itself.

## Timing
- Reset values: imem_req=0, imem_addr=0, inst_valid=0, icode/ifun/rA/rB=0, valC=0, valP=0, pc=RESET_PC, stat=1 (AOK), busy=0, state=IDLE.
- rst asserted mid-operation clears everything immediately, including an outstanding imem_req.
- imem_req and imem_addr are registered. They stay asserted and stable until the cycle imem_ack=1.
- After an ack, the next byte's request appears on the following cycle (back-to-back, no idle cycle).
- With zero-wait memory, an N-byte instruction gives inst_valid exactly N+1 cycles after entering FETCH: N request cycles, then a registered PRESENT.
- imem_ack while imem_req=0 is ignored.
- stat updates on the same edge as the entry into HALT.

## Configuration
- FETCH_CTRL_AUTOINC_EN
  - Defined: WAIT_PC is bypassed. On acceptance, pc<=valP and the controller returns to FETCH. A new_pc_valid in the same cycle overrides with new_pc. A later new_pc_valid is ignored.
  - Undefined: behaviour as in Operation; an explicit new_pc_valid is required after every instruction.

## Test plan
- nop (0x10) at 0, ack every cycle, start pulse -> inst_valid on cycle 2; icode=1, ifun=0, valP=1, valC=0.
- irmovq bytes 30 F3 EF CD AB 89 67 45 23 01 at pc=0 -> 10 acks; rA=F, rB=3, valC=0x0123456789ABCDEF, valP=10. With inst_ready low 5 cycles, fields stay stable. Accept with new_pc=10 -> imem_addr=10 next cycle.
- Ack delayed 3 cycles per byte on call (0x80 + 8-byte dest 0x40) -> imem_addr held, imem_req high throughout; valC=0x40, valP=9.
- Byte 0 = 0xC0 -> stat=4 (INS), no inst_valid, imem_req=0. A subsequent start is ignored.
- IMEM_SIZE=16, irmovq at pc=12 -> bytes 12..15 read, no request for 16; stat=3 (ADR), no inst_valid.
- halt (0x00) accepted -> stat=2. rst asserted mid-FETCH in the next run -> imem_req drops immediately, pc=RESET_PC, stat=1.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the sequential Y86-64 core.
// Reads instruction bytes one at a time over a req/ack handshake, length-decodes
// and assembles the instruction, and hands it to decode with a valid/ready pair.
// Optional feature macro: FETCH_CTRL_AUTOINC_EN -- when defined, an accepted
// instruction advances pc to valP (or to new_pc if offered in the same cycle)
// and fetching resumes without waiting for an explicit new_pc_valid.
module fetch_ctrl #(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter logic [63:0] IMEM_SIZE = 64'd1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [63:0] new_pc_i,
   input  logic        new_pc_valid_i,
   output logic        imem_req_o,
   output logic [63:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [7:0]  imem_rdata_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [3:0]  icode_o,
   output logic [3:0]  ifun_o,
   output logic [3:0]  ra_o,
   output logic [3:0]  rb_o,
   output logic [63:0] valc_o,
   output logic [63:0] valp_o,
   output logic [63:0] pc_o,
   output logic [2:0]  stat_o,
   output logic        busy_o
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_PRESENT = 3'd2,
      S_WAIT_PC = 3'd3,
      S_HALT    = 3'd4
   } state_e;

   // Instruction length in bytes, selected by icode.
   function automatic logic [3:0] inst_len(input logic [3:0] icode);
      logic [3:0] len;
      case (icode)
         4'h0, 4'h1, 4'h9:       len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
         4'h7, 4'h8:             len = 4'd9;
         4'h3, 4'h4, 4'h5:       len = 4'd10;
         default:                len = 4'd1;
      endcase
      return len;
   endfunction

   // Legal icode/ifun combinations; cmovXX and jXX take ifun 0..6, OPq 0..3.
   function automatic logic inst_legal(input logic [3:0] icode, input logic [3:0] ifun);
      logic ok;
      case (icode)
         4'h2, 4'h7:  ok = (ifun <= 4'd6);
         4'h6:        ok = (ifun <= 4'd3);
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                      ok = (ifun == 4'd0);
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [3:0]  k_q, k_d;
   logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
   logic [63:0] valc_q, valc_d, valp_q, valp_d;
   logic [2:0]  stat_q, stat_d;
   logic        req_q, req_d;
   logic [63:0] addr_q, addr_d;
   logic        inst_valid_q, inst_valid_d;
   logic        busy_q, busy_d;

   logic        ack_s, accept_s;
   logic [3:0]  cur_icode_s, cur_ifun_s, cur_len_s;
   logic        inst_ok_s, last_byte_s;
   logic [63:0] next_addr_s;
   logic        next_addr_bad_s;
   logic        valc_hit_s;
   logic [2:0]  valc_idx_s;
   logic [5:0]  valc_shamt_s;
   logic        launch_s, launch_bad_s;
   logic [63:0] launch_pc_s;

   // Per-byte decode of the current fetch step (byte 0 comes straight off the bus).
   always_comb begin
      ack_s           = (state_q == S_FETCH) && req_q && imem_ack_i;
      accept_s        = (state_q == S_PRESENT) && inst_ready_i;
      cur_icode_s     = (k_q == 4'd0) ? imem_rdata_i[7:4] : icode_q;
      cur_ifun_s      = (k_q == 4'd0) ? imem_rdata_i[3:0] : ifun_q;
      cur_len_s       = inst_len(cur_icode_s);
      inst_ok_s       = inst_legal(cur_icode_s, cur_ifun_s);
      last_byte_s     = ((k_q + 4'd1) == cur_len_s);
      next_addr_s     = pc_q + {60'd0, k_q} + 64'd1;
      next_addr_bad_s = (next_addr_s >= IMEM_SIZE);
      if ((cur_icode_s == 4'h7) || (cur_icode_s == 4'h8)) begin
         valc_hit_s = (k_q >= 4'd1);
         valc_idx_s = k_q[2:0] - 3'd1;
      end else if ((cur_icode_s == 4'h3) || (cur_icode_s == 4'h4) || (cur_icode_s == 4'h5)) begin
         valc_hit_s = (k_q >= 4'd2);
         valc_idx_s = k_q[2:0] - 3'd2;
      end else begin
         valc_hit_s = 1'b0;
         valc_idx_s = 3'd0;
      end
      valc_shamt_s = {valc_idx_s, 3'b000};
   end

   // Decide whether a new fetch starts this cycle and from which pc.
   always_comb begin
      launch_s    = 1'b0;
      launch_pc_s = pc_q;
      case (state_q)
         S_IDLE: begin
            launch_s    = start_i;
            launch_pc_s = pc_q;
         end
         S_PRESENT: begin
`ifdef FETCH_CTRL_AUTOINC_EN
            launch_s    = inst_ready_i && (icode_q != 4'h0);
            launch_pc_s = new_pc_valid_i ? new_pc_i : valp_q;
`else
            launch_s    = inst_ready_i && (icode_q != 4'h0) && new_pc_valid_i;
            launch_pc_s = new_pc_i;
`endif
         end
         S_WAIT_PC: begin
            launch_s    = new_pc_valid_i;
            launch_pc_s = new_pc_i;
         end
         default: begin
            launch_s    = 1'b0;
            launch_pc_s = pc_q;
         end
      endcase
      launch_bad_s = (launch_pc_s >= IMEM_SIZE);
   end

   // Next-state logic of the fetch sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (launch_s) begin
               state_d = launch_bad_s ? S_HALT : S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (ack_s) begin
               if ((k_q == 4'd0) && !inst_ok_s) begin
                  state_d = S_HALT;
               end else if (last_byte_s) begin
                  state_d = S_PRESENT;
               end else if (next_addr_bad_s) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_FETCH;
            end
         end
         S_PRESENT: begin
            if (accept_s) begin
               if (icode_q == 4'h0) begin
                  state_d = S_HALT;
               end else if (launch_s) begin
                  state_d = launch_bad_s ? S_HALT : S_FETCH;
               end else begin
                  state_d = S_WAIT_PC;
               end
            end else begin
               state_d = S_PRESENT;
            end
         end
         S_WAIT_PC: begin
            if (launch_s) begin
               state_d = launch_bad_s ? S_HALT : S_FETCH;
            end else begin
               state_d = S_WAIT_PC;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and the instruction datapath.
   always_comb begin
      pc_d         = pc_q;
      k_d          = k_q;
      icode_d      = icode_q;
      ifun_d       = ifun_q;
      ra_d         = ra_q;
      rb_d         = rb_q;
      valc_d       = valc_q;
      valp_d       = valp_q;
      stat_d       = stat_q;
      req_d        = req_q;
      addr_d       = addr_q;
      inst_valid_d = inst_valid_q;
      busy_d       = (state_d == S_FETCH) || (state_d == S_PRESENT) || (state_d == S_WAIT_PC);

      if (ack_s) begin
         k_d = k_q + 4'd1;
         if (k_q == 4'd0) begin
            // New instruction: clear fields that shorter encodings do not set.
            icode_d = imem_rdata_i[7:4];
            ifun_d  = imem_rdata_i[3:0];
            ra_d    = 4'h0;
            rb_d    = 4'h0;
            valc_d  = 64'd0;
         end else if (k_q == 4'd1) begin
            ra_d = imem_rdata_i[7:4];
            rb_d = imem_rdata_i[3:0];
         end else begin
            ra_d = ra_q;
         end
         if (valc_hit_s) begin
            valc_d = valc_q | ({56'd0, imem_rdata_i} << valc_shamt_s);
         end else begin
            valc_d = valc_d;
         end
         if ((k_q == 4'd0) && !inst_ok_s) begin
            req_d  = 1'b0;
            stat_d = STAT_INS;
         end else if (last_byte_s) begin
            req_d        = 1'b0;
            inst_valid_d = 1'b1;
            valp_d       = pc_q + {60'd0, cur_len_s};
         end else if (next_addr_bad_s) begin
            req_d  = 1'b0;
            stat_d = STAT_ADR;
         end else begin
            addr_d = next_addr_s;
         end
      end else if (accept_s) begin
         inst_valid_d = 1'b0;
         if (icode_q == 4'h0) begin
            stat_d = STAT_HLT;
         end else begin
            stat_d = stat_q;
         end
      end else begin
         inst_valid_d = inst_valid_q;
      end

      if (launch_s) begin
         pc_d         = launch_pc_s;
         k_d          = 4'd0;
         inst_valid_d = 1'b0;
         if (launch_bad_s) begin
            req_d  = 1'b0;
            stat_d = STAT_ADR;
         end else begin
            req_d  = 1'b1;
            addr_d = launch_pc_s;
         end
      end else begin
         pc_d = pc_d;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q         <= RESET_PC;
         k_q          <= 4'd0;
         icode_q      <= 4'h0;
         ifun_q       <= 4'h0;
         ra_q         <= 4'h0;
         rb_q         <= 4'h0;
         valc_q       <= 64'd0;
         valp_q       <= 64'd0;
         stat_q       <= STAT_AOK;
         req_q        <= 1'b0;
         addr_q       <= 64'd0;
         inst_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         k_q          <= k_d;
         icode_q      <= icode_d;
         ifun_q       <= ifun_d;
         ra_q         <= ra_d;
         rb_q         <= rb_d;
         valc_q       <= valc_d;
         valp_q       <= valp_d;
         stat_q       <= stat_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         inst_valid_q <= inst_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign imem_req_o   = req_q;
   assign imem_addr_o  = addr_q;
   assign inst_valid_o = inst_valid_q;
   assign icode_o      = icode_q;
   assign ifun_o       = ifun_q;
   assign ra_o         = ra_q;
   assign rb_o         = rb_q;
   assign valc_o       = valc_q;
   assign valp_o       = valp_q;
   assign pc_o         = pc_q;
   assign stat_o       = stat_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a byte-wide memory responder of
// programmable ack latency.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] new_pc;
   logic        new_pc_valid;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [7:0]  imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [3:0]  icode, ifun, ra, rb;
   logic [63:0] valc, valp, pc;
   logic [2:0]  stat;
   logic        busy;

   logic [7:0]  mem [0:1023];
   int          ack_delay;
   int          wait_cnt;
   int          oob_cnt;
   int          checks;
   int          errors;

   fetch_ctrl #(
      .RESET_PC (64'd0),
      .IMEM_SIZE(64'd1024)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .new_pc_i      (new_pc),
      .new_pc_valid_i(new_pc_valid),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (imem_ack),
      .imem_rdata_i  (imem_rdata),
      .inst_valid_o  (inst_valid),
      .inst_ready_i  (inst_ready),
      .icode_o       (icode),
      .ifun_o        (ifun),
      .ra_o          (ra),
      .rb_o          (rb),
      .valc_o        (valc),
      .valp_o        (valp),
      .pc_o          (pc),
      .stat_o        (stat),
      .busy_o        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: acks a pending request after ack_delay waiting cycles.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      wait_cnt   = 0;
      oob_cnt    = 0;
      forever begin
         @(negedge clk);
         if (imem_req && !rst) begin
            if (imem_addr >= 64'd1024) begin
               oob_cnt++;
               imem_ack = 1'b0;
            end else if (wait_cnt >= ack_delay) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr[9:0]];
               wait_cnt   = 0;
            end else begin
               imem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   // Start from IDLE on a nop at address 0 and wait for it to be presented.
   task automatic run_nop_at_zero();
      mem[0] = 8'h10;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("nop_valid", {63'd0, inst_valid}, 64'd1);
   endtask

   initial begin
      int          cyc;
      logic [63:0] prev_addr;
      logic        prev_ack;

      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      start        = 1'b0;
      new_pc       = 64'd0;
      new_pc_valid = 1'b0;
      inst_ready   = 1'b0;
      ack_delay    = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

      // Reset values
      step();
      step();
      chk("rst_req",   {63'd0, imem_req}, 64'd0);
      chk("rst_addr",  imem_addr, 64'd0);
      chk("rst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_icode", {60'd0, icode}, 64'd0);
      chk("rst_valc",  valc, 64'd0);
      chk("rst_valp",  valp, 64'd0);
      chk("rst_pc",    pc, 64'd0);
      chk("rst_stat",  {61'd0, stat}, 64'd1);
      chk("rst_busy",  {63'd0, busy}, 64'd0);
      rst = 1'b0;
      step();
      chk("idle_req",  {63'd0, imem_req}, 64'd0);

      // nop at 0: request in cycle 1, inst_valid in cycle 2
      mem[0] = 8'h10;
      start  = 1'b1;
      step();
      start  = 1'b0;
      chk("nop_c1_req",   {63'd0, imem_req}, 64'd1);
      chk("nop_c1_addr",  imem_addr, 64'd0);
      chk("nop_c1_busy",  {63'd0, busy}, 64'd1);
      chk("nop_c1_valid", {63'd0, inst_valid}, 64'd0);
      step();
      chk("nop_c2_valid", {63'd0, inst_valid}, 64'd1);
      chk("nop_icode",    {60'd0, icode}, 64'd1);
      chk("nop_ifun",     {60'd0, ifun}, 64'd0);
      chk("nop_valp",     valp, 64'd1);
      chk("nop_valc",     valc, 64'd0);
      chk("nop_req_off",  {63'd0, imem_req}, 64'd0);

      // Accept without new_pc: controller parks in WAIT_PC
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("wait_valid", {63'd0, inst_valid}, 64'd0);
      chk("wait_busy",  {63'd0, busy}, 64'd1);
      chk("wait_req",   {63'd0, imem_req}, 64'd0);

      // irmovq at 0 via new_pc: 10 bytes, inst_valid 11 cycles after entry
      mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'hEF; mem[3] = 8'hCD; mem[4] = 8'hAB;
      mem[5] = 8'h89; mem[6] = 8'h67; mem[7] = 8'h45; mem[8] = 8'h23; mem[9] = 8'h01;
      new_pc       = 64'd0;
      new_pc_valid = 1'b1;
      step();
      new_pc_valid = 1'b0;
      cyc = 1;
      while (!inst_valid && cyc < 50) begin
         step();
         cyc++;
      end
      chk("irm_valid",  {63'd0, inst_valid}, 64'd1);
      chk("irm_cycles", cyc, 64'd11);
      chk("irm_icode",  {60'd0, icode}, 64'd3);
      chk("irm_ra",     {60'd0, ra}, 64'hF);
      chk("irm_rb",     {60'd0, rb}, 64'd3);
      chk("irm_valc",   valc, 64'h0123456789ABCDEF);
      chk("irm_valp",   valp, 64'd10);
      for (int j = 0; j < 5; j++) begin
         step();
         chk("irm_hold_valid", {63'd0, inst_valid}, 64'd1);
         chk("irm_hold_valc",  valc, 64'h0123456789ABCDEF);
         chk("irm_hold_rb",    {60'd0, rb}, 64'd3);
      end

      // Accept with new_pc=10 in the same cycle: request for 10 next cycle.
      // call at 10 with 3 wait cycles per byte.
      mem[10] = 8'h80; mem[11] = 8'h40;
      ack_delay    = 3;
      inst_ready   = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = 64'd10;
      step();
      inst_ready   = 1'b0;
      new_pc_valid = 1'b0;
      chk("acc_addr",  imem_addr, 64'd10);
      chk("acc_req",   {63'd0, imem_req}, 64'd1);
      chk("acc_valid", {63'd0, inst_valid}, 64'd0);
      cyc       = 1;
      prev_addr = imem_addr;
      prev_ack  = imem_ack;
      while (!inst_valid && cyc < 100) begin
         step();
         cyc++;
         if (!inst_valid) begin
            chk("call_req_high", {63'd0, imem_req}, 64'd1);
            if (!prev_ack) chk("call_addr_held", imem_addr, prev_addr);
         end
         prev_addr = imem_addr;
         prev_ack  = imem_ack;
      end
      chk("call_valid",  {63'd0, inst_valid}, 64'd1);
      chk("call_cycles", cyc, 64'd37);
      chk("call_icode",  {60'd0, icode}, 64'd8);
      chk("call_valc",   valc, 64'h40);
      chk("call_valp",   valp, 64'd19);
      chk("call_pc",     pc, 64'd10);

      // Illegal byte 0xC0 at 20: stat INS, no inst_valid, request dropped
      mem[20]      = 8'hC0;
      ack_delay    = 0;
      inst_ready   = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = 64'd20;
      step();
      inst_ready   = 1'b0;
      new_pc_valid = 1'b0;
      chk("ins_c1_addr", imem_addr, 64'd20);
      step();
      chk("ins_stat",  {61'd0, stat}, 64'd4);
      chk("ins_req",   {63'd0, imem_req}, 64'd0);
      chk("ins_valid", {63'd0, inst_valid}, 64'd0);
      chk("ins_busy",  {63'd0, busy}, 64'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("ins_start_req",  {63'd0, imem_req}, 64'd0);
      chk("ins_start_stat", {61'd0, stat}, 64'd4);
      chk("ins_start_busy", {63'd0, busy}, 64'd0);

      // halt accepted: stat HLT
      do_reset();
      chk("rst2_stat", {61'd0, stat}, 64'd1);
      chk("rst2_pc",   pc, 64'd0);
      mem[0] = 8'h00;
      start  = 1'b1;
      step();
      start  = 1'b0;
      step();
      chk("hlt_valid", {63'd0, inst_valid}, 64'd1);
      chk("hlt_icode", {60'd0, icode}, 64'd0);
      chk("hlt_valp",  valp, 64'd1);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      chk("hlt_stat",  {61'd0, stat}, 64'd2);
      chk("hlt_valid_off", {63'd0, inst_valid}, 64'd0);
      chk("hlt_busy",  {63'd0, busy}, 64'd0);
      chk("hlt_req",   {63'd0, imem_req}, 64'd0);

      // irmovq at 1020 runs off the end of the 1024-byte memory
      do_reset();
      run_nop_at_zero();
      mem[1020] = 8'h30; mem[1021] = 8'hF3; mem[1022] = 8'h00; mem[1023] = 8'h00;
      inst_ready   = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = 64'd1020;
      step();
      inst_ready   = 1'b0;
      new_pc_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) step();
         chk("adr_addr", imem_addr, 64'd1020 + 64'(j));
         chk("adr_req",  {63'd0, imem_req}, 64'd1);
      end
      step();
      chk("adr_stat",  {61'd0, stat}, 64'd3);
      chk("adr_req_off", {63'd0, imem_req}, 64'd0);
      chk("adr_valid", {63'd0, inst_valid}, 64'd0);
      chk("adr_pc",    pc, 64'd1020);
      step();
      step();
      step();
      chk("adr_req_later", {63'd0, imem_req}, 64'd0);
      chk("adr_no_oob",    oob_cnt, 64'd0);

      // rst asserted mid-FETCH clears everything immediately
      do_reset();
      run_nop_at_zero();
      mem[256]     = 8'h30;
      ack_delay    = 3;
      inst_ready   = 1'b1;
      new_pc_valid = 1'b1;
      new_pc       = 64'h100;
      step();
      inst_ready   = 1'b0;
      new_pc_valid = 1'b0;
      chk("mid_req",  {63'd0, imem_req}, 64'd1);
      chk("mid_addr", imem_addr, 64'h100);
      step();
      chk("mid_pc",   pc, 64'h100);
      rst = 1'b1;
      #1;
      chk("mrst_req",   {63'd0, imem_req}, 64'd0);
      chk("mrst_addr",  imem_addr, 64'd0);
      chk("mrst_pc",    pc, 64'd0);
      chk("mrst_stat",  {61'd0, stat}, 64'd1);
      chk("mrst_busy",  {63'd0, busy}, 64'd0);
      chk("mrst_valid", {63'd0, inst_valid}, 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_req", {63'd0, imem_req}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
